// File: rtl/battery_monitor.sv
// Emulated battery charge counter and RUN/LOW/CHARGE/FULL state manager for the cleaner.
// Optional LOW_WARN_EN adds a registered-decode Warn output (RUN with Level <= 2*LOW_TH).
//
// state  | meaning
// RUN    | cleaning allowed, draining on Tick
// LOW    | cut off at/below LOW_TH, waiting for dock
// CHARGE | docked and charging, Battery held low
// FULL   | docked at CAPACITY, Battery allowed
module battery_monitor #(
  parameter int CAP_W       = 10,
  parameter int CAPACITY    = 1000,
  parameter int LOW_TH      = 100,
  parameter int RESUME_TH   = 300,
  parameter int DRAIN_V     = 4,
  parameter int DRAIN_M     = 2,
  parameter int DRAIN_S     = 3,
  parameter int DRAIN_B     = 1,
  parameter int CHARGE_RATE = 10
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Tick,
  input  logic             Docked,
  input  logic             Vacuum,
  input  logic             Mop,
  input  logic             Sanitize,
  input  logic             Brake,
  output logic             Battery,
  output logic [CAP_W-1:0] Level,
  output logic             Charging,
`ifdef LOW_WARN_EN
  output logic             Warn,
`endif
  output logic             Full
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LOW    = 2'd1,
    ST_CHARGE = 2'd2,
    ST_FULL   = 2'd3
  } state_t;

  localparam logic [CAP_W:0] CAP_X  = (CAP_W+1)'(CAPACITY);
  localparam logic [CAP_W:0] LOW_X  = (CAP_W+1)'(LOW_TH);
  localparam logic [CAP_W:0] RES_X  = (CAP_W+1)'(RESUME_TH);
  localparam logic [CAP_W:0] RATE_X = (CAP_W+1)'(CHARGE_RATE);

  state_t           state, state_nxt;
  logic [CAP_W-1:0] level_nxt;
  logic [CAP_W:0]   level_x, drain, charged;

  assign level_x = {1'b0, Level};

  // Drain and charge sums are one bit wider so saturation can be detected before truncation.
  always_comb begin
    drain = '0;
    if (Vacuum)   drain = drain + (CAP_W+1)'(DRAIN_V);
    if (Mop)      drain = drain + (CAP_W+1)'(DRAIN_M);
    if (Sanitize) drain = drain + (CAP_W+1)'(DRAIN_S);
    if (Brake)    drain = drain + (CAP_W+1)'(DRAIN_B);
    charged = level_x + RATE_X;
    level_nxt = Level;
    if (Tick) begin
      if (Docked)
        level_nxt = (charged > CAP_X) ? CAP_X[CAP_W-1:0] : charged[CAP_W-1:0];
      else if (drain >= level_x)
        level_nxt = '0;
      else
        level_nxt = Level - drain[CAP_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (Docked)
          state_nxt = (level_x == CAP_X) ? ST_FULL : ST_CHARGE;
        else if (level_x <= LOW_X)
          state_nxt = ST_LOW;
      end
      ST_LOW: begin
        if (Docked) state_nxt = ST_CHARGE;
      end
      ST_CHARGE: begin
        if (level_x == CAP_X)
          state_nxt = ST_FULL;
        else if (!Docked)
          state_nxt = (level_x >= RES_X) ? ST_RUN : ST_LOW;
      end
      ST_FULL: begin
        if (!Docked) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= ST_RUN;
      Level <= CAP_X[CAP_W-1:0];
    end else begin
      state <= state_nxt;
      Level <= level_nxt;
    end
  end

  assign Battery  = (state == ST_RUN) || (state == ST_FULL);
  assign Charging = (state == ST_CHARGE);
  assign Full     = (state == ST_FULL);

`ifdef LOW_WARN_EN
  assign Warn = (state == ST_RUN) && (level_x <= (CAP_W+1)'(2 * LOW_TH));
`endif

endmodule

// File: tb/tb_battery_monitor.sv
// Self-checking bench for battery_monitor: directed scenarios with literal expectations,
// then randomized Tick/Docked/function traffic compared every cycle against a behavioural model.
module tb_battery_monitor;

  localparam int CAPACITY = 1000;
  localparam int LOW_TH = 100;
  localparam int RESUME_TH = 300;
  localparam int M_RUN = 0, M_LOW = 1, M_CHG = 2, M_FULL = 3;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Tick = 1'b0, Docked = 1'b0;
  logic       Vacuum = 1'b0, Mop = 1'b0, Sanitize = 1'b0, Brake = 1'b0;
  logic       Battery, Charging, Full;
  logic [9:0] Level;
`ifdef LOW_WARN_EN
  logic       Warn;
`endif

  int n_checks = 0;
  int n_err = 0;
  bit started = 1'b0;

  battery_monitor dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Docked(Docked),
    .Vacuum(Vacuum), .Mop(Mop), .Sanitize(Sanitize), .Brake(Brake),
    .Battery(Battery), .Level(Level), .Charging(Charging),
`ifdef LOW_WARN_EN
    .Warn(Warn),
`endif
    .Full(Full)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: charge level as an integer, plus a mode number.
  int m_level;
  int m_mode;

  function automatic int level_after(int lvl, bit tk, bit dk, bit v, bit m, bit s, bit b);
    int d;
    if (!tk) return lvl;
    if (dk) return (lvl + 10 > CAPACITY) ? CAPACITY : lvl + 10;
    d = 4 * v + 2 * m + 3 * s + 1 * b;
    return (d >= lvl) ? 0 : lvl - d;
  endfunction

  function automatic int mode_after(int md, int lvl, bit dk);
    if (md == M_RUN) begin
      if (dk) return (lvl == CAPACITY) ? M_FULL : M_CHG;
      return (lvl <= LOW_TH) ? M_LOW : M_RUN;
    end
    if (md == M_LOW) return dk ? M_CHG : M_LOW;
    if (md == M_CHG) begin
      if (lvl == CAPACITY) return M_FULL;
      if (!dk) return (lvl >= RESUME_TH) ? M_RUN : M_LOW;
      return M_CHG;
    end
    return dk ? M_FULL : M_RUN;
  endfunction

  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_level <= CAPACITY;
      m_mode  <= M_RUN;
    end else begin
      m_level <= level_after(m_level, Tick, Docked, Vacuum, Mop, Sanitize, Brake);
      m_mode  <= mode_after(m_mode, m_level, Docked);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (started && !Reset) begin
      check("model_level", int'(Level), m_level);
      check("model_battery", int'(Battery), int'(m_mode == M_RUN || m_mode == M_FULL));
      check("model_charging", int'(Charging), int'(m_mode == M_CHG));
      check("model_full", int'(Full), int'(m_mode == M_FULL));
`ifdef LOW_WARN_EN
      check("model_warn", int'(Warn), int'(m_mode == M_RUN && m_level <= 2 * LOW_TH));
`endif
    end
  end

  task automatic drive(input bit t, input bit d, input bit v, input bit m, input bit s, input bit b);
    @(negedge Clock);
    Tick = t; Docked = d; Vacuum = v; Mop = m; Sanitize = s; Brake = b;
  endtask

  task automatic ticks(input int n, input bit d, input bit v, input bit m, input bit s, input bit b);
    repeat (n) begin
      drive(1'b1, d, v, m, s, b);
      drive(1'b0, d, v, m, s, b);
    end
  endtask

  initial begin
    bit prev_tick;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    started = 1'b1;
    @(negedge Clock);
    check("reset_level", int'(Level), 1000);
    check("reset_battery", int'(Battery), 1);
    check("reset_charging", int'(Charging), 0);
    check("reset_full", int'(Full), 0);

    ticks(100, 0, 1, 1, 1, 0);
    check("drain9_level", int'(Level), 100);
    check("battery_before_state", int'(Battery), 1);
    drive(0, 0, 0, 0, 0, 0);
    check("battery_low", int'(Battery), 0);

    ticks(19, 0, 1, 0, 0, 1);
    check("level5", int'(Level), 5);
    ticks(1, 0, 1, 1, 1, 0);
    check("no_wrap_level", int'(Level), 0);
    check("no_wrap_battery", int'(Battery), 0);

    ticks(30, 1, 0, 0, 0, 0);
    check("charge300_level", int'(Level), 300);
    check("charge300_charging", int'(Charging), 1);
    check("charge300_battery", int'(Battery), 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("resume_battery", int'(Battery), 1);

    ticks(50, 0, 1, 0, 0, 0);
    check("drain4_level", int'(Level), 100);
    ticks(95, 1, 1, 0, 0, 0);
    check("sat_level", int'(Level), 1000);
    check("sat_full", int'(Full), 1);
    check("sat_battery", int'(Battery), 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    check("undock_full", int'(Full), 0);
    check("undock_battery", int'(Battery), 1);

    ticks(75, 0, 1, 1, 1, 1);
    check("drain10_level", int'(Level), 250);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    check("charge250_charging", int'(Charging), 1);
    #2 Reset = 1'b1;
    #1;
    check("midreset_level", int'(Level), 1000);
    check("midreset_battery", int'(Battery), 1);
    check("midreset_charging", int'(Charging), 0);
    drive(0, 0, 0, 0, 0, 0);
    Reset = 1'b0;

`ifdef LOW_WARN_EN
    ticks(80, 0, 1, 1, 1, 1);
    check("warn_level", int'(Level), 200);
    check("warn_on", int'(Warn), 1);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    check("warn_docked", int'(Warn), 0);
    drive(0, 0, 0, 0, 0, 0);
`endif

    prev_tick = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit t, d;
      @(negedge Clock);
      if (Reset) Reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) Reset = 1'b1;
      t = !prev_tick && ($urandom_range(0, 2) != 0);
      d = ($urandom_range(0, 39) == 0) ? !Docked : Docked;
      Tick = t; Docked = d;
      Vacuum = $urandom_range(0, 1) == 1;
      Mop = $urandom_range(0, 1) == 1;
      Sanitize = $urandom_range(0, 1) == 1;
      Brake = $urandom_range(0, 1) == 1;
      prev_tick = t;
    end
    @(negedge Clock);
    Tick = 1'b0; Reset = 1'b0;
    @(negedge Clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
